// File: rtl/cov_pkg.sv
// Shared types and default framing constants for the covariance front end.
// The gate's parameters and the bench both default to these constants.
package cov_pkg;

  localparam int NUM_CH_D      = 4;
  localparam int DATA_WIDTH_D  = 16;
  localparam int FRAME_SIZE_D  = 2048;
  localparam int SKIP_D        = 48;
  localparam int DESIRED_D     = 2000;
  localparam int FCNT_WIDTH_D  = 32;
  localparam int IDX_W         = $clog2(FRAME_SIZE_D);

  typedef enum logic {IDLE, ACTIVE} gate_state_t;
  typedef logic [NUM_CH_D*DATA_WIDTH_D-1:0] chan_bus_t;

endpackage

// File: rtl/cov_frame_gate.sv
// Frame gate ahead of cov_matrix: drops the frame head, forwards a fixed window
// with sof/eof markers, and flags short/long frames.
module cov_frame_gate
  import cov_pkg::*;
#(
  parameter int NUM_CH          = NUM_CH_D,
  parameter int DATA_WIDTH      = DATA_WIDTH_D,
  parameter int FRAME_SIZE      = FRAME_SIZE_D,
  parameter int SKIP_SAMPLES    = SKIP_D,
  parameter int DESIRED_SAMPLES = DESIRED_D,
  parameter int FCNT_WIDTH      = FCNT_WIDTH_D
) (
  input  logic                         clk_x4,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         err_clear,
  input  logic                         data_in_valid,
  input  logic                         frame_sync,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_i_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_q_in,
  output logic                         data_out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_i_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_q_out,
  output logic                         sof_out,
  output logic                         eof_out,
  output logic                         frame_abort,
  output logic [FCNT_WIDTH-1:0]        frame_counter,
  output logic                         short_frame_err,
  output logic                         long_frame_err
);

  localparam int IW = $clog2(FRAME_SIZE);
  localparam logic [IW-1:0] SKIP_I   = IW'(SKIP_SAMPLES);
  localparam logic [IW-1:0] LAST_FWD = IW'(SKIP_SAMPLES + DESIRED_SAMPLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_SIZE - 1);

  if ((SKIP_SAMPLES + DESIRED_SAMPLES > FRAME_SIZE) || (DESIRED_SAMPLES < 1)) begin : g_bad_cfg
    $error("cov_frame_gate: forwarding window does not fit in the frame");
  end

  gate_state_t   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, cur_idx;
  logic          synced_q, synced_d;
  logic          fwd, sof_d, eof_d, abort_d, short_set, long_set;

  // idx_q holds the index the next valid sample will take within the frame.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    synced_d  = synced_q;
    cur_idx   = '0;
    fwd       = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    abort_d   = 1'b0;
    short_set = 1'b0;
    long_set  = 1'b0;
    if (data_in_valid) begin
      if (frame_sync && state_q == ACTIVE && idx_q != '0) begin
        short_set = 1'b1;
        // sof already out (idx past SKIP) but eof not yet (idx not past LAST_FWD)
        abort_d   = (idx_q > SKIP_I) && (idx_q <= LAST_FWD);
      end
      if (frame_sync && !enable) begin
        // a refused frame is a legitimate boundary: its samples are not "long"
        state_d  = IDLE;
        idx_d    = '0;
        synced_d = 1'b0;
      end else if (frame_sync || state_q == ACTIVE) begin
        cur_idx  = frame_sync ? '0 : idx_q;
        synced_d = 1'b1;
        fwd      = (cur_idx >= SKIP_I) && (cur_idx <= LAST_FWD);
        sof_d    = (cur_idx == SKIP_I);
        eof_d    = (cur_idx == LAST_FWD);
        if (cur_idx == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          state_d = ACTIVE;
          idx_d   = cur_idx + IW'(1);
        end
      end else if (synced_q) begin
        long_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_x4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      synced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      synced_q <= synced_d;
    end
  end

  always_ff @(posedge clk_x4 or negedge rst_n) begin
    if (!rst_n) begin
      data_out_valid  <= 1'b0;
      ch_i_out        <= '0;
      ch_q_out        <= '0;
      sof_out         <= 1'b0;
      eof_out         <= 1'b0;
      frame_abort     <= 1'b0;
      frame_counter   <= '0;
      short_frame_err <= 1'b0;
      long_frame_err  <= 1'b0;
    end else begin
      data_out_valid <= fwd;
      sof_out        <= sof_d;
      eof_out        <= eof_d;
      frame_abort    <= abort_d;
      if (fwd) begin
        ch_i_out <= ch_i_in;
        ch_q_out <= ch_q_in;
      end
      if (eof_d) frame_counter <= frame_counter + FCNT_WIDTH'(1);
      // a set in the same cycle as err_clear wins
      if (short_set)      short_frame_err <= 1'b1;
      else if (err_clear) short_frame_err <= 1'b0;
      if (long_set)       long_frame_err  <= 1'b1;
      else if (err_clear) long_frame_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cov_frame_gate.sv
// Randomized bench for cov_frame_gate against a per-sample frame model.
module tb_cov_frame_gate;
  import cov_pkg::*;

  localparam int SK = SKIP_D;
  localparam int DS = DESIRED_D;
  localparam int FS = FRAME_SIZE_D;

  logic clk_x4 = 1'b0, rst_n = 1'b0;
  logic enable = 1'b0, err_clear = 1'b0, data_in_valid = 1'b0, frame_sync = 1'b0;
  chan_bus_t ch_i_in = '0, ch_q_in = '0, ch_i_out, ch_q_out;
  logic data_out_valid, sof_out, eof_out, frame_abort, short_frame_err, long_frame_err;
  logic [FCNT_WIDTH_D-1:0] frame_counter;

  always #5 clk_x4 = ~clk_x4;

  cov_frame_gate #(
    .NUM_CH(NUM_CH_D), .DATA_WIDTH(DATA_WIDTH_D), .FRAME_SIZE(FS),
    .SKIP_SAMPLES(SK), .DESIRED_SAMPLES(DS), .FCNT_WIDTH(FCNT_WIDTH_D)
  ) dut (
    .clk_x4(clk_x4), .rst_n(rst_n), .enable(enable), .err_clear(err_clear),
    .data_in_valid(data_in_valid), .frame_sync(frame_sync),
    .ch_i_in(ch_i_in), .ch_q_in(ch_q_in),
    .data_out_valid(data_out_valid), .ch_i_out(ch_i_out), .ch_q_out(ch_q_out),
    .sof_out(sof_out), .eof_out(eof_out), .frame_abort(frame_abort),
    .frame_counter(frame_counter),
    .short_frame_err(short_frame_err), .long_frame_err(long_frame_err)
  );

  int total = 0, bad = 0;
  int n_out, n_sof, n_eof, n_abort;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: m_seen = samples taken in the current frame (-1 = outside any frame),
  // m_fwd = samples forwarded in the current frame
  int  m_seen, m_fwd;
  bit  m_sync;
  logic e_valid, e_sof, e_eof, e_abort, e_short, e_long;
  logic [FCNT_WIDTH_D-1:0] e_cnt;
  chan_bus_t e_i, e_q;

  task automatic model_reset();
    m_seen = -1; m_fwd = 0; m_sync = 0;
    e_valid = 0; e_sof = 0; e_eof = 0; e_abort = 0; e_short = 0; e_long = 0;
    e_cnt = '0; e_i = '0; e_q = '0;
  endtask

  task automatic model(input logic v, input logic s, input logic en, input logic clr);
    bit take, sset, lset;
    int k;
    take = 0; sset = 0; lset = 0;
    e_valid = 0; e_sof = 0; e_eof = 0; e_abort = 0;
    if (v) begin
      if (s) begin
        if (m_seen > 0) sset = 1;
        if (m_fwd > 0 && m_fwd < DS) e_abort = 1;
        m_fwd = 0;
        if (en) begin m_seen = 0; m_sync = 1; take = 1; end
        else    begin m_seen = -1; m_sync = 0; end
      end else if (m_seen >= 0) take = 1;
      else if (m_sync) lset = 1;
    end
    if (take) begin
      k = m_seen;
      if (k >= SK && k < SK + DS) begin
        e_valid = 1; e_i = ch_i_in; e_q = ch_q_in;
        m_fwd++;
        e_sof = (m_fwd == 1);
        e_eof = (m_fwd == DS);
        if (e_eof) e_cnt = e_cnt + 1'b1;
      end
      m_seen = (k + 1 == FS) ? -1 : k + 1;
    end
    if (sset) e_short = 1; else if (clr) e_short = 0;
    if (lset) e_long = 1;  else if (clr) e_long = 0;
  endtask

  task automatic step(input logic v, input logic s, input logic en, input logic clr);
    data_in_valid = v; frame_sync = s; enable = en; err_clear = clr;
    ch_i_in = chan_bus_t'({$urandom(), $urandom()});
    ch_q_in = chan_bus_t'({$urandom(), $urandom()});
    model(v, s, en, clr);
    @(posedge clk_x4); #1;
    chk("valid", data_out_valid, e_valid);
    chk("sof", sof_out, e_sof);
    chk("eof", eof_out, e_eof);
    chk("abort", frame_abort, e_abort);
    chk("short_err", short_frame_err, e_short);
    chk("long_err", long_frame_err, e_long);
    chk("fcnt", frame_counter, e_cnt);
    if (e_valid) begin
      chk("data_i", ch_i_out, e_i);
      chk("data_q", ch_q_out, e_q);
    end
    n_out += int'(data_out_valid); n_sof += int'(sof_out);
    n_eof += int'(eof_out); n_abort += int'(frame_abort);
  endtask

  task automatic run(input int n, input logic sync0, input logic en, input int gap);
    for (int k = 0; k < n; k++) begin
      step(1'b1, sync0 && k == 0, en, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, en, 1'b0);
    end
  endtask

  task automatic tally_clr();
    n_out = 0; n_sof = 0; n_eof = 0; n_abort = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, data_out_valid, 1'b0);
    chk({tag, "_sof"}, sof_out, 1'b0);
    chk({tag, "_eof"}, eof_out, 1'b0);
    chk({tag, "_abort"}, frame_abort, 1'b0);
    chk({tag, "_fcnt"}, frame_counter, '0);
    chk({tag, "_short"}, short_frame_err, 1'b0);
    chk({tag, "_long"}, long_frame_err, 1'b0);
    chk({tag, "_di"}, ch_i_out, '0);
    chk({tag, "_dq"}, ch_q_out, '0);
  endtask

  initial begin
    model_reset();
    tally_clr();
    repeat (2) @(posedge clk_x4);
    #1 chk_zero("rst");
    rst_n = 1'b1;

    // 1: single full-rate frame
    tally_clr();
    run(FS, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_nout", n_out, 2000);
    chk("t1_nsof", n_sof, 1);
    chk("t1_neof", n_eof, 1);
    chk("t1_fcnt", frame_counter, 1);
    chk("t1_short", short_frame_err, 0);
    chk("t1_long", long_frame_err, 0);

    // 2: three frames at 1-of-4 pacing
    tally_clr();
    for (int f = 0; f < 3; f++) run(FS, 1'b1, 1'b1, 3);
    chk("t2_nout", n_out, 6000);
    chk("t2_nsof", n_sof, 3);
    chk("t2_neof", n_eof, 3);
    chk("t2_fcnt", frame_counter, 4);

    // 3: early sync at idx 1000 truncates frame 1
    tally_clr();
    run(1000, 1'b1, 1'b1, 0);
    run(FS, 1'b1, 1'b1, 0);
    chk("t3_short", short_frame_err, 1);
    chk("t3_nabort", n_abort, 1);
    chk("t3_nsof", n_sof, 2);
    chk("t3_neof", n_eof, 1);
    chk("t3_nout", n_out, 952 + 2000);
    chk("t3_fcnt", frame_counter, 5);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_short_clr", short_frame_err, 0);

    // 4: one sample past the frame end
    tally_clr();
    run(FS + 1, 1'b1, 1'b1, 0);
    chk("t4_long", long_frame_err, 1);
    chk("t4_neof", n_eof, 1);
    chk("t4_fcnt", frame_counter, 6);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4_long_clr", long_frame_err, 0);

    // 5: refused frame, then enable dropping mid-frame
    tally_clr();
    run(FS, 1'b1, 1'b0, 0);
    chk("t5_nout_off", n_out, 0);
    run(10, 1'b1, 1'b1, 0);
    run(FS - 10, 1'b0, 1'b0, 0);
    chk("t5_nout", n_out, 2000);
    chk("t5_neof", n_eof, 1);
    chk("t5_fcnt", frame_counter, 7);
    chk("t5_long", long_frame_err, 0);

    // 6: asynchronous reset mid-frame
    tally_clr();
    run(501, 1'b1, 1'b1, 0);
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    model_reset();
    rst_n = 1'b1;
    tally_clr();
    run(100, 1'b0, 1'b1, 0);
    chk("t6_nout", n_out, 0);
    chk("t6_long", long_frame_err, 0);
    run(FS, 1'b1, 1'b1, 0);
    chk("t6_fcnt", frame_counter, 1);

    // 7: random traffic
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      logic v, s, en, clr;
      v   = ($urandom_range(0, 3) != 0);
      s   = v && ($urandom_range(0, 399) == 0);
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 199) == 0);
      step(v, s, en, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
